// File: rtl/gold_pkg.sv
// gold_pkg: shared config-word layout, default tap masks and legal parameter ranges for gold_gen_mc
package gold_pkg;
  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] seed;
  } cfg_t;
  localparam logic [4:0] TAPS_A_DEF = 5'b10100;
  localparam logic [4:0] TAPS_B_DEF = 5'b11110;
  localparam int LFSR_W_MIN = 3;
  localparam int LFSR_W_MAX = 8;
  localparam int N_CH_MIN = 1;
  localparam int N_CH_MAX = 16;
endpackage

// File: rtl/lfsr_fib.sv
// lfsr_fib: Fibonacci LFSR shifting toward the MSB; load has priority over step
module lfsr_fib #(
  parameter int W = 5,
  parameter logic [W-1:0] TAPS = '1
) (
  input  logic         clk,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);
  always_ff @(posedge clk)
    state <= load ? seed : step ? {state[W-2:0], ^(state & TAPS)} : state;
endmodule

// File: rtl/gold_gen_mc.sv
// gold_gen_mc: multi-channel Gold code generator with per-channel seed reload at epoch boundaries
module gold_gen_mc
  import gold_pkg::*;
#(
  parameter int LFSR_W = 5,
  parameter int N_CH = 4,
  parameter int DIV = 4,
  parameter logic [LFSR_W-1:0] TAPS_A = TAPS_A_DEF,
  parameter logic [LFSR_W-1:0] TAPS_B = TAPS_B_DEF,
  parameter logic [LFSR_W-1:0] INIT_B = '1
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic            en,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  input  logic [15:0]     s_axis_tdata,
  output logic [N_CH-1:0] code_gold,
  output logic            chip_en_o,
  output logic            strobe_sig_o,
  output logic            cfg_err_o
);
  localparam int P = (1 << LFSR_W) - 1;
  localparam int DW = $clog2(DIV + 1);
  cfg_t cfg;
  logic [DW-1:0] div;
  logic [LFSR_W-1:0] idx, pseed, a;
  logic [LFSR_W-1:0] b [N_CH];
  logic [7:0] pch;
  logic pend, take, bad, chip, wrap;
  assign cfg = cfg_t'(s_axis_tdata);
  assign s_axis_tready = ~rst & ~pend;
  assign chip_en_o = chip;
  assign strobe_sig_o = wrap;
  always_comb begin
    chip = en & ~rst & (div == DW'(DIV - 1));
    wrap = chip & (idx == LFSR_W'(P - 1));
    take = s_axis_tvalid & s_axis_tready;
    bad = (cfg.seed[LFSR_W-1:0] == '0) | (cfg.ch >= 8'(N_CH));
  end
  // a rejected word is consumed but never occupies the slot
  always_ff @(posedge clkin)
    if (rst) begin
      div <= '0;
      idx <= '0;
      pend <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      cfg_err_o <= take & bad;
      if (en) div <= (div == DW'(DIV - 1)) ? '0 : div + 1'b1;
      if (chip) idx <= wrap ? '0 : idx + 1'b1;
      if (wrap) pend <= 1'b0;
      if (take & ~bad) begin
        pend <= 1'b1;
        pch <= cfg.ch;
        pseed <= cfg.seed[LFSR_W-1:0];
      end
    end
  lfsr_fib #(.W(LFSR_W), .TAPS(TAPS_A)) u_a (
    .clk(clkin), .step(chip), .load(rst | wrap), .seed({LFSR_W{1'b1}}), .state(a)
  );
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    lfsr_fib #(.W(LFSR_W), .TAPS(TAPS_B)) u_b (
      .clk(clkin), .step(chip), .load(rst | (wrap & pend & (pch == 8'(c)))),
      .seed(rst ? INIT_B : pseed), .state(b[c])
    );
    assign code_gold[c] = a[LFSR_W-1] ^ b[c][LFSR_W-1];
  end
endmodule

// File: tb/tb_gold_gen_mc.sv
// tb_gold_gen_mc: random and directed stimulus against a chip-index based Gold code reference model
module tb_gold_gen_mc;
  import gold_pkg::*;
  localparam int W = 5, N = 4, D = 4, P = 31;
  logic clkin = 0, rst = 1, en = 0, s_axis_tvalid = 0;
  logic s_axis_tready, chip_en_o, strobe_sig_o, cfg_err_o;
  logic [15:0] s_axis_tdata = '0;
  logic [N-1:0] code_gold;
  int n_cmp = 0, n_err = 0, cnt = 0, m_pch = 0, nchip = 0, nstrobe = 0, k;
  bit m_pend = 0, m_err = 0, took = 0;
  logic [W-1:0] m_pseed = '1;
  logic [W-1:0] m_seed [N];

  gold_gen_mc dut (
    .clkin(clkin), .rst(rst), .en(en), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .code_gold(code_gold),
    .chip_en_o(chip_en_o), .strobe_sig_o(strobe_sig_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clkin = ~clkin;

  function automatic logic [W-1:0] adv(input logic [W-1:0] s, input logic [W-1:0] t, input int n);
    logic [W-1:0] r = s;
    for (int i = 0; i < n; i++) r = {r[W-2:0], ^(r & t)};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: model advances on the rising edge, outputs compared on the falling edge
  task automatic step();
    bit chip, take, bad;
    int idx;
    logic [W-1:0] ra, rb;
    logic [N-1:0] g;
    @(posedge clkin);
    took = 0;
    if (rst) begin
      cnt = 0; m_pend = 0; m_err = 0;
      foreach (m_seed[c]) m_seed[c] = '1;
    end else begin
      chip = en && (cnt % D) == D - 1;
      take = s_axis_tvalid && !m_pend;
      took = take;
      bad = s_axis_tdata[W-1:0] == 0 || s_axis_tdata[15:8] >= N;
      if (chip && (cnt / D) % P == P - 1 && m_pend) begin
        m_seed[m_pch] = m_pseed;
        m_pend = 0;
      end
      if (en) cnt++;
      m_err = take && bad;
      if (take && !bad) begin
        m_pend = 1; m_pch = s_axis_tdata[15:8]; m_pseed = s_axis_tdata[W-1:0];
      end
    end
    @(negedge clkin);
    idx = (cnt / D) % P;
    chip = en && !rst && (cnt % D) == D - 1;
    ra = adv('1, TAPS_A_DEF, idx);
    for (int c = 0; c < N; c++) begin
      rb = adv(m_seed[c], TAPS_B_DEF, idx);
      g[c] = ra[W-1] ^ rb[W-1];
    end
    chk("chip_en", chip_en_o, chip);
    chk("strobe", strobe_sig_o, chip && idx == P - 1);
    chk("tready", s_axis_tready, !rst && !m_pend);
    chk("cfg_err", cfg_err_o, m_err);
    chk("code_gold", code_gold, g);
    nchip += chip_en_o;
    nstrobe += strobe_sig_o;
  endtask

  task automatic run_to(input int t);
    for (int i = 0; i < 4 * D * P && (cnt / D) % P != t; i++) step();
  endtask

  task automatic send(input logic [7:0] ch, input logic [7:0] seed);
    s_axis_tdata = {ch, seed};
    s_axis_tvalid = 1;
    for (int i = 0; i < 4 * D * P && !s_axis_tready; i++) step();
    step();
    s_axis_tvalid = 0;
  endtask

  initial begin
    rst = 1;
    repeat (3) step();
    rst = 0; en = 1; nchip = 0; nstrobe = 0;
    repeat (200) step();
    chk("chips200", nchip, 50);
    chk("strobes200", nstrobe, 1);
    run_to(10);
    send(8'd2, 8'h03);
    repeat (140) step();
    s_axis_tdata = {8'd1, 8'h09};
    s_axis_tvalid = 1;
    k = 0;
    for (int i = 0; i < 400 && k < 2; i++) begin
      step();
      if (took) begin
        k++;
        s_axis_tdata = {8'd3, 8'h11};
      end
    end
    s_axis_tvalid = 0;
    chk("b2b_accepts", k, 2);
    repeat (130) step();
    send(8'd1, 8'h00);
    send(8'd7, 8'h05);
    repeat (5) step();
    run_to(0);
    send(8'd0, 8'h07);
    run_to(20);
    rst = 1;
    repeat (2) step();
    rst = 0;
    repeat (150) step();
    send(8'd3, 8'h15);
    run_to(30);
    step();
    en = 0;
    k = nchip;
    repeat (50) step();
    chk("frozen_chips", nchip - k, 0);
    en = 1;
    repeat (150) step();
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 9) != 0;
      rst = $urandom_range(0, 499) == 0;
      s_axis_tvalid = $urandom_range(0, 3) == 0;
      s_axis_tdata = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 31))};
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gold_gen_mc.md
GOLD_GEN_MC -- requirements
Module: gold_gen_mc

Interface
REQ-001 SHALL have parameter LFSR_W, default 5, meaning LFSR length in bits (legal range 3..8); code period is 2^LFSR_W-1 chips.
REQ-002 SHALL have parameter N_CH, default 4, meaning number of parallel Gold code channels (legal range 1..16).
REQ-003 SHALL have parameter DIV, default 4, meaning clkin cycles per chip (legal range 1..255).
REQ-004 SHALL have parameters TAPS_A and TAPS_B, defaults 5'b10100 and 5'b11110, meaning the feedback tap masks of the preferred m-sequence pair.
REQ-005 SHALL have parameter INIT_B, default all-ones, meaning the reset seed of every channel's B register.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 clkin  input  1  system clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 en  input  1  chip-timing enable; low freezes all counters and LFSRs.
REQ-010 s_axis_tvalid  input  1  config word valid.
REQ-011 s_axis_tready  output  1  config word accepted when high with tvalid.
REQ-012 s_axis_tdata  input  16  [7:0] seed for register B (low LFSR_W bits used), [15:8] channel index.
REQ-013 code_gold  output  N_CH  per-channel Gold chip.
REQ-014 chip_en_o  output  1  one-cycle pulse per chip step.
REQ-015 strobe_sig_o  output  1  one-cycle pulse at the start of each code period.
REQ-016 cfg_err_o  output  1  one-cycle pulse on rejected config word.

Function
REQ-017 Divider counts 0..DIV-1 while en=1; chip_en_o pulses in the cycle the divider equals DIV-1, and the divider wraps to 0.
REQ-018 Chip index counts 0..2^LFSR_W-2 on each chip_en_o and wraps to 0.
REQ-019 On chip_en_o, shared register A and every B register shift one Fibonacci step; feedback is the XOR of the bits selected by the tap mask.
REQ-020 code_gold[c] = A[LFSR_W-1] XOR B_c[LFSR_W-1], driven from registers, so it changes in the cycle after chip_en_o.
REQ-021 strobe_sig_o pulses in the cycle that the chip index wraps to 0, coincident with that chip_en_o.
REQ-022 On the wrapping chip_en_o (epoch boundary), A reloads all-ones; a pending seed loads into B of its channel instead of a shift step; other channels shift normally.
REQ-023 Config handshake is a single pending slot; tready=1 only when the slot is empty and not in reset; a transfer fills the slot.
REQ-024 The slot empties on the epoch-boundary load; tready rises in the following cycle.
REQ-025 Seed with zero low LFSR_W bits, or channel index >= N_CH: word is accepted (tready handshake completes), discarded, slot stays empty, cfg_err_o pulses the cycle after.
REQ-026 en=0 on an epoch boundary defers the pending load until the boundary actually occurs; handshakes still proceed while en=0.

Reset
REQ-027 On rst: divider=0, chip index=0, A=all-ones, each B=INIT_B, slot empty, tready=0, chip_en_o=0, strobe_sig_o=0, cfg_err_o=0; code_gold=0 with default seeds.
REQ-028 Reset mid-period or with a pending seed discards the seed; first chip_en_o occurs DIV cycles after rst deasserts; first strobe after one full period.

Structure
REQ-029 Package gold_pkg SHALL hold the config word typedef (seed, channel fields), default tap constants, and LFSR_W/N_CH legal-range constants.
REQ-030 A sub-module lfsr_fib (parameters W, TAPS; inputs step, load, seed; output state) SHALL implement A and each B, instantiated N_CH+1 times.

Verification
REQ-031 Defaults, en=1, 200 cycles -> chip_en_o every 4 cycles, strobe_sig_o every 124 cycles, code_gold matches reference Gold model for all channels.
REQ-032 Config {ch=2, seed=5'h03} at chip 10 -> channel 2 changes only after the next strobe, then matches a model seeded 5'h03; channels 0,1,3 unaffected.
REQ-033 Two back-to-back words -> second held with tready=0 until the cycle after the epoch load, then accepted.
REQ-034 Seed 0 or ch=7 with N_CH=4 -> cfg_err_o pulse, no output change, tready stays 1.
REQ-035 rst asserted at chip 20 with a pending seed -> all outputs equal REQ-027 values, seed lost, sequence restarts from chip 0.
REQ-036 en=0 for 50 cycles spanning an epoch boundary -> no chip_en_o, no strobe, code_gold frozen; resumes with no lost or extra chips.
